// File: rtl/pipe_stage_chain.sv
// Parametrised valid/ready register chain with per-stage flush, bubble collapse and occupancy count.
// Optional PIPE_STATS_EN adds accept_cnt / flush_cnt statistics ports.

module pipe_stage_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              i_ld,
    input  logic              i_kill,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_nv,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              w_nv;

    // Item that would sit in this stage after the edge, before flush is applied.
    assign w_nv = i_ld ? i_valid : r_valid;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= w_nv & ~i_kill;
            if (i_ld) r_data <= i_data;
        end
    end

    assign o_nv    = w_nv;
    assign o_valid = r_valid;
    assign o_data  = r_data;
endmodule

module pipe_stage_chain #(
    parameter  int DATA_W = 32,
    parameter  int STAGES = 4,
    localparam int OCC_W  = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic [STAGES-1:0] flush,
`ifdef PIPE_STATS_EN
    output logic [31:0]       accept_cnt,
    output logic [31:0]       flush_cnt,
`endif
    output logic [OCC_W-1:0]  occupancy
);
    logic [STAGES-1:0]             w_rdy;
    logic [STAGES-1:0]             w_nv;
    logic [STAGES-1:0]             w_valid;
    logic [STAGES-1:0]             w_up_valid;
    logic [STAGES-1:0][DATA_W-1:0] w_data;
    logic [STAGES-1:0][DATA_W-1:0] w_up_data;
    logic [OCC_W-1:0]              w_occ;

    // Ready ripples from the output end; a stage can load if empty or if its successor moves.
    always_comb begin
        w_rdy = '0;
        w_rdy[STAGES-1] = ~w_valid[STAGES-1] | out_ready;
        for (int i = STAGES - 2; i >= 0; i--)
            w_rdy[i] = ~w_valid[i] | w_rdy[i+1];
    end

    always_comb begin
        w_up_valid    = '0;
        w_up_data     = '0;
        w_up_valid[0] = in_valid;
        w_up_data[0]  = in_data;
        for (int i = 1; i < STAGES; i++) begin
            w_up_valid[i] = w_valid[i-1];
            w_up_data[i]  = w_data[i-1];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        pipe_stage_reg #(.DATA_W(DATA_W)) u_stage (
            .clk     (clk),
            .Reset   (Reset),
            .i_ld    (w_rdy[g]),
            .i_kill  (flush[g]),
            .i_valid (w_up_valid[g]),
            .i_data  (w_up_data[g]),
            .o_nv    (w_nv[g]),
            .o_valid (w_valid[g]),
            .o_data  (w_data[g])
        );
    end

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < STAGES; i++)
            w_occ = w_occ + OCC_W'(w_valid[i]);
    end

    assign in_ready  = w_rdy[0];
    assign out_valid = w_valid[STAGES-1];
    assign out_data  = w_data[STAGES-1];
    assign occupancy = w_occ;

`ifdef PIPE_STATS_EN
    logic [31:0] r_accept_cnt;
    logic [31:0] r_flush_cnt;
    logic [31:0] w_kill_cnt;

    // Counts only live items destroyed, so flushing an empty stage is free.
    always_comb begin
        w_kill_cnt = '0;
        for (int i = 0; i < STAGES; i++)
            w_kill_cnt = w_kill_cnt + 32'(w_nv[i] & flush[i]);
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_accept_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            r_accept_cnt <= r_accept_cnt + 32'(in_valid & w_rdy[0]);
            r_flush_cnt  <= r_flush_cnt + w_kill_cnt;
        end
    end

    assign accept_cnt = r_accept_cnt;
    assign flush_cnt  = r_flush_cnt;
`endif
endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain (STAGES=4): streaming, backpressure, collapse, flush, reset, stats.
module tb_pipe_stage_chain;
    localparam int DW = 32;
    localparam int ST = 4;
    localparam int OW = 3;

    logic          clk = 1'b0;
    logic          Reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [ST-1:0] flush = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [OW-1:0] occupancy;
`ifdef PIPE_STATS_EN
    logic [31:0]   accept_cnt;
    logic [31:0]   flush_cnt;
`endif

    int n_chk = 0;
    int n_pass = 0;

    pipe_stage_chain #(.DATA_W(DW), .STAGES(ST)) dut (
        .clk       (clk),
        .Reset     (Reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
`ifdef PIPE_STATS_EN
        .accept_cnt(accept_cnt),
        .flush_cnt (flush_cnt),
`endif
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        int acc, outn;
        logic exp_v;
        logic [31:0] got[$];
        logic [31:0] exp6[8];
        exp6 = '{32'h61, 32'h62, 32'h63, 32'h64, 32'h65, 32'h68, 32'h69, 32'h6A};

        // reset state
        #3;
        check("rst out_valid", out_valid, 0);
        check("rst occupancy", occupancy, 0);
        check("rst in_ready", in_ready, 1);
        check("rst out_data", out_data, 0);
        tick;
        tick;
        Reset = 1'b1;

        // 1: back-to-back stream 1..10, out_ready=1
        out_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            in_valid = (c < 10);
            in_data  = (c < 10) ? 32'(c + 1) : 32'h0;
            tick;
            exp_v = (c >= 3 && c <= 12);
            check("t1 out_valid", out_valid, exp_v);
            if (exp_v) check("t1 out_data", out_data, 32'(c - 2));
            acc  = (c + 1 < 10) ? c + 1 : 10;
            outn = (c - 3 < 0) ? 0 : ((c - 3 > 10) ? 10 : c - 3);
            check("t1 occupancy", occupancy, 32'(acc - outn));
        end
        in_valid = 1'b0;

        // 2: stall full chain for 6 cycles, then release
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 6; c++) begin
            in_data = 32'h21 + 32'(c);
            #1;
            check("t2 in_ready", in_ready, (c < 4));
            tick;
            check("t2 occupancy", occupancy, (c < 3) ? 32'(c + 1) : 32'd4);
            check("t2 out_valid", out_valid, (c >= 3));
            if (c >= 3) check("t2 out_data stable", out_data, 32'h21);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("t2 drain valid", out_valid, 1);
            check("t2 drain order", out_data, 32'h21 + 32'(c));
            tick;
        end
        check("t2 empty", occupancy, 0);

        // 3: single stalled item, later items collapse behind it
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h55;
        tick;
        check("t3 occ first", occupancy, 1);
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick;
            check("t3 occ idle", occupancy, 1);
        end
        check("t3 out_valid", out_valid, 1);
        check("t3 out_data", out_data, 32'h55);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 32'h56 + 32'(k);
            tick;
            check("t3 occ step", occupancy, 32'(2 + k));
        end
        in_valid = 1'b0;
        #1;
        check("t3 in_ready full", in_ready, 0);

        // 4: flush the two middle stages of a full, stalled chain
        flush = 4'b0110;
        tick;
        flush = '0;
        check("t4 occupancy", occupancy, 2);
        check("t4 head kept", out_data, 32'h55);
        out_ready = 1'b1;
        got.delete();
        for (int c = 0; c < 8; c++) begin
            #1;
            if (out_valid) got.push_back(out_data);
            tick;
        end
        check("t4 count", got.size(), 2);
        if (got.size() >= 2) begin
            check("t4 first", got[0], 32'h55);
            check("t4 second", got[1], 32'h58);
        end

        // 5: asynchronous reset between edges mid-stream
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = 32'h71 + 32'(k);
            tick;
        end
        in_valid = 1'b0;
        Reset = 1'b0;
        #1;
        check("t5 out_valid", out_valid, 0);
        check("t5 occupancy", occupancy, 0);
        check("t5 in_ready", in_ready, 1);
        check("t5 out_data", out_data, 0);
`ifdef PIPE_STATS_EN
        check("t5 accept_cnt rst", accept_cnt, 0);
`endif
        tick;
        Reset = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h77;
        tick;
        in_valid = 1'b0;
        check("t5 restart occ", occupancy, 1);
        tick;
        tick;
        check("t5 latency early", out_valid, 0);
        tick;
        check("t5 latency valid", out_valid, 1);
        check("t5 latency data", out_data, 32'h77);
        tick;
        check("t5 drained", occupancy, 0);

        // 6: 10 items, two live items flushed in flight
        Reset = 1'b0;
        #1;
`ifdef PIPE_STATS_EN
        check("t6 accept rst", accept_cnt, 0);
        check("t6 flush rst", flush_cnt, 0);
`endif
        tick;
        Reset = 1'b1;
        out_ready = 1'b1;
        got.delete();
        for (int c = 0; c < 20; c++) begin
            in_valid = (c < 10);
            in_data  = 32'h61 + 32'(c);
            flush    = (c == 5) ? 4'b0001 : ((c == 8) ? 4'b0100 : 4'b0000);
            #1;
            if (out_valid) got.push_back(out_data);
            tick;
        end
        in_valid = 1'b0;
        flush = '0;
        check("t6 count", got.size(), 8);
        if (got.size() == 8)
            for (int i = 0; i < 8; i++) check("t6 order", got[i], exp6[i]);
        check("t6 empty", occupancy, 0);
`ifdef PIPE_STATS_EN
        check("t6 accept_cnt", accept_cnt, 10);
        check("t6 flush_cnt", flush_cnt, 2);
        flush = 4'b1111;
        tick;
        flush = '0;
        check("t6 flush empty", flush_cnt, 2);
        check("t6 accept hold", accept_cnt, 10);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
